// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the iterative divider
package div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division step (combinational)
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  assign shifted         = {rem[WIDTH-1:0], quo_msb};
  assign {borrow, trial} = {1'b0, shifted} - {2'b0, divisor};

  // A set rem MSB means the shifted partial remainder overflowed past the divisor range.
  assign q_bit    = rem[WIDTH] | ~borrow;
  assign next_rem = q_bit ? trial : shifted;

endmodule

// File: rtl/iterative_div.sv
// rtl/iterative_div.sv - multi-cycle unsigned divider, one quotient bit per clock
module iterative_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             dbz;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo_msb (quo[WIDTH-1]),
    .divisor (dvsr),
    .next_rem(step_rem),
    .q_bit   (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      DIV_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (divisor == '0) ? DIV_DONE : DIV_CALC;
      end
      DIV_CALC: begin
        if (count == '0) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // quo shifts the dividend out at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (in_valid) begin
            dvsr  <= divisor;
            count <= COUNT_INIT;
            dbz   <= (divisor == '0);
            if (divisor == '0) begin
              quo <= '1;
              rem <= {1'b0, dividend};
            end else begin
              quo <= dividend;
              rem <= '0;
            end
          end
        end
        DIV_CALC: begin
          rem   <= step_rem;
          quo   <= {quo[WIDTH-2:0], step_bit};
          count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo;
  assign remainder   = rem[WIDTH-1:0];
  assign div_by_zero = dbz;

endmodule
